// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// The return-address stack is only built when PC_RAS_EN is defined.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_t;

    localparam int unsigned PC_DEF_ADDR_W    = 32;
    localparam int unsigned PC_DEF_INC       = 1;
    localparam int unsigned PC_DEF_RESET_VEC = 0;
    localparam int unsigned PC_DEF_RAS_DEPTH = 4;

    // Reset is handled by the registers themselves, so it is not part of the decode.
    function automatic pc_op_t pc_decode(input logic stall, input logic ret,
                                         input logic call, input logic branch);
        pc_op_t op;
        if (stall) begin
            op = PC_HOLD;
        end else if (ret) begin
            op = PC_RET;
        end else if (call) begin
            op = PC_CALL;
        end else if (branch) begin
            op = PC_BRANCH;
        end else begin
            op = PC_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO: pushing while full overwrites the oldest entry,
// so the most recent RAS_DEPTH return addresses always survive.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = PC_DEF_ADDR_W,
    parameter int unsigned RAS_DEPTH = PC_DEF_RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [ADDR_W-1:0]          i_data,
    output logic [ADDR_W-1:0]          o_top,
    output logic [$clog2(RAS_DEPTH):0] o_cnt
);

    localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  w_top_idx;

    // Power-of-2 depth lets the pointer wrap naturally.
    assign w_top_idx = r_wp - PTR_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + PTR_W'(1);
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_pop && (r_cnt != '0)) begin
            r_wp  <= w_top_idx;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, branch and optional call/return stack.
// Define PC_RAS_EN to build the return-address stack; otherwise call == branch, ret == increment.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = PC_DEF_ADDR_W,
    parameter int unsigned INC       = PC_DEF_INC,
    parameter int unsigned RESET_VEC = PC_DEF_RESET_VEC,
    parameter int unsigned RAS_DEPTH = PC_DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] branchAdrx,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_underflow
);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("RAS_DEPTH must be a power of 2 and at least 2");
    end

    pc_op_t            w_op;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_op     = pc_decode(stall, ret, call, branch);
    assign w_pc_inc = r_pc + ADDR_W'(INC);
    assign pc       = r_pc;

`ifdef PC_RAS_EN
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [ADDR_W-1:0] w_top;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              r_underflow;

    assign w_empty = (w_cnt == '0);
    assign w_push  = (w_op == PC_CALL);
    assign w_pop   = (w_op == PC_RET) && !w_empty;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (w_pc_inc),
        .o_top  (w_top),
        .o_cnt  (w_cnt)
    );

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            PC_HOLD:            w_pc_next = r_pc;
            PC_BRANCH, PC_CALL: w_pc_next = branchAdrx;
            PC_RET:             w_pc_next = w_empty ? w_pc_inc : w_top;
            default:            w_pc_next = w_pc_inc;
        endcase
    end

    // A stalled cycle decodes to PC_HOLD, which clears the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= (w_op == PC_RET) && w_empty;
        end
    end

    assign ras_empty     = w_empty;
    assign ras_full      = (w_cnt == CNT_W'(RAS_DEPTH));
    assign ras_underflow = r_underflow;
`else
    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            PC_HOLD:            w_pc_next = r_pc;
            PC_BRANCH, PC_CALL: w_pc_next = branchAdrx;
            default:            w_pc_next = w_pc_inc;
        endcase
    end

    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= ADDR_W'(RESET_VEC);
        end else begin
            r_pc <= w_pc_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: three instances (default, INC=4/RESET_VEC=0x100, ADDR_W=8) share stimulus
// and are checked every cycle against a stack-as-list model, plus literal spot checks.
module tb_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, stall, branch, call, ret;
    logic [31:0] adrx;

    logic [31:0] pc0, pc1;
    logic [7:0]  pc8;
    logic        emp0, emp1, emp8, ful0, ful1, ful8, uf0, uf1, uf8;

    always #5 clk = ~clk;

    pc_unit #(.ADDR_W(32), .INC(1), .RESET_VEC(0), .RAS_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .call(call), .ret(ret),
        .branchAdrx(adrx), .pc(pc0), .ras_empty(emp0), .ras_full(ful0), .ras_underflow(uf0)
    );
    pc_unit #(.ADDR_W(32), .INC(4), .RESET_VEC(32'h100), .RAS_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .call(call), .ret(ret),
        .branchAdrx(adrx), .pc(pc1), .ras_empty(emp1), .ras_full(ful1), .ras_underflow(uf1)
    );
    pc_unit #(.ADDR_W(8), .INC(1), .RESET_VEC(0), .RAS_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .call(call), .ret(ret),
        .branchAdrx(adrx[7:0]), .pc(pc8), .ras_empty(emp8), .ras_full(ful8), .ras_underflow(uf8)
    );

    logic [31:0] d_pc  [3];
    logic        d_emp [3];
    logic        d_ful [3];
    logic        d_uf  [3];
    assign d_pc[0] = pc0;
    assign d_pc[1] = pc1;
    assign d_pc[2] = {24'h0, pc8};
    assign d_emp[0] = emp0;
    assign d_emp[1] = emp1;
    assign d_emp[2] = emp8;
    assign d_ful[0] = ful0;
    assign d_ful[1] = ful1;
    assign d_ful[2] = ful8;
    assign d_uf[0]  = uf0;
    assign d_uf[1]  = uf1;
    assign d_uf[2]  = uf8;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: stack is a list, index 0 oldest; a full push drops the oldest entry.
    logic [31:0] m_mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_inc  [3] = '{32'd1, 32'd4, 32'd1};
    logic [31:0] m_rv   [3] = '{32'h0, 32'h100, 32'h0};
    logic [31:0] m_pc   [3];
    logic [31:0] m_stk  [3][DEPTH];
    int          m_cnt  [3];
    logic        m_uf   [3];
    bit          m_valid = 1'b0;

    task automatic model_step(input int k);
        logic [31:0] nxt;
        if (rst) begin
            m_pc[k]  = m_rv[k];
            m_cnt[k] = 0;
            m_uf[k]  = 1'b0;
        end else if (stall) begin
            m_uf[k] = 1'b0;
        end else begin
            nxt     = (m_pc[k] + m_inc[k]) & m_mask[k];
            m_uf[k] = 1'b0;
            if (ret) begin
                if (RAS_ON && m_cnt[k] > 0) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    m_pc[k]  = m_stk[k][m_cnt[k]];
                end else begin
                    m_pc[k] = nxt;
                    m_uf[k] = RAS_ON;
                end
            end else if (call) begin
                if (RAS_ON) begin
                    if (m_cnt[k] == DEPTH) begin
                        for (int i = 0; i < DEPTH - 1; i++) m_stk[k][i] = m_stk[k][i+1];
                        m_cnt[k] = DEPTH - 1;
                    end
                    m_stk[k][m_cnt[k]] = nxt;
                    m_cnt[k] = m_cnt[k] + 1;
                end
                m_pc[k] = adrx & m_mask[k];
            end else if (branch) begin
                m_pc[k] = adrx & m_mask[k];
            end else begin
                m_pc[k] = nxt;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) model_step(k);
            if (rst) m_valid = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("pc[%0d]", k), d_pc[k], m_pc[k]);
                    chk($sformatf("empty[%0d]", k), {31'h0, d_emp[k]}, {31'h0, m_cnt[k] == 0});
                    chk($sformatf("full[%0d]", k), {31'h0, d_ful[k]}, {31'h0, m_cnt[k] == DEPTH});
                    chk($sformatf("underflow[%0d]", k), {31'h0, d_uf[k]}, {31'h0, m_uf[k]});
                end
            end
        end
    end

    task automatic cyc(input logic s, input logic b, input logic c, input logic r,
                       input logic [31:0] a);
        stall  = s;
        branch = b;
        call   = c;
        ret    = r;
        adrx   = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; adrx = '0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lit_rst_pc0", pc0, 32'h0);
        chk("lit_rst_pc1", pc1, 32'h100);
        chk("lit_rst_empty", {31'h0, emp0}, 32'h1);
        chk("lit_rst_full", {31'h0, ful0}, 32'h0);
        chk("lit_rst_uf", {31'h0, uf0}, 32'h0);
        rst = 1'b0;

        cyc(0, 0, 0, 0, 0);
        chk("lit_inc_pc0_1", pc0, 32'h1);
        chk("lit_inc_pc1_104", pc1, 32'h104);
        cyc(0, 0, 0, 0, 0);
        chk("lit_inc_pc1_108", pc1, 32'h108);
        cyc(0, 0, 0, 0, 0);
        chk("lit_inc_pc0_3", pc0, 32'h3);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lit_inc_pc0_5", pc0, 32'h5);

        // Call to 0x40 from 5, idle twice, return.
        cyc(0, 0, 1, 0, 32'h40);
        chk("lit_call_pc", pc0, 32'h40);
        chk("lit_call_empty", {31'h0, emp0}, {31'h0, !RAS_ON});
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lit_idle_pc", pc0, 32'h42);
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret_pc", pc0, RAS_ON ? 32'h6 : 32'h43);
        chk("lit_ret_empty", {31'h0, emp0}, 32'h1);

        // Five nested calls overflow a 4-deep stack.
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 0, 32'h100 * i);
        chk("lit_ovf_full", {31'h0, ful0}, {31'h0, RAS_ON});
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret_a5", pc0, RAS_ON ? 32'h401 : 32'h501);
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret_a4", pc0, RAS_ON ? 32'h301 : 32'h502);
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret_a3", pc0, RAS_ON ? 32'h201 : 32'h503);
        cyc(0, 0, 0, 1, 0);
        chk("lit_ret_a2", pc0, RAS_ON ? 32'h101 : 32'h504);
        chk("lit_ret_empty2", {31'h0, emp0}, 32'h1);
        cyc(0, 0, 0, 1, 0);
        chk("lit_under_pc", pc0, RAS_ON ? 32'h102 : 32'h505);
        chk("lit_under_pulse", {31'h0, uf0}, {31'h0, RAS_ON});
        cyc(0, 0, 0, 0, 0);
        chk("lit_under_clear", {31'h0, uf0}, 32'h0);

        // Stall clears a pending underflow and ignores strobes.
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 32'h77);
        chk("lit_stall_pc", pc0, RAS_ON ? 32'h104 : 32'h507);
        chk("lit_stall_uf", {31'h0, uf0}, 32'h0);

        // Priority: ret beats call and branch; top is 0x20.
        cyc(0, 1, 0, 0, 32'h1F);
        cyc(0, 0, 1, 0, 32'h80);
        cyc(1, 0, 1, 1, 32'h90);
        chk("lit_stall2_pc", pc0, 32'h80);
        chk("lit_stall2_empty", {31'h0, emp0}, {31'h0, !RAS_ON});
        cyc(0, 1, 1, 1, 32'h99);
        chk("lit_prio_pc", pc0, RAS_ON ? 32'h20 : 32'h81);
        chk("lit_prio_empty", {31'h0, emp0}, 32'h1);

        // Wrap at all-ones, and a call at all-ones pushes zero.
        cyc(0, 1, 0, 0, 32'hFFFF_FFFF);
        chk("lit_wrap_pre8", {24'h0, pc8}, 32'hFF);
        cyc(0, 0, 0, 0, 0);
        chk("lit_wrap_pc8", {24'h0, pc8}, 32'h0);
        chk("lit_wrap_pc0", pc0, 32'h0);
        chk("lit_wrap_pc1", pc1, 32'h3);
        cyc(0, 1, 0, 0, 32'hFFFF_FFFF);
        cyc(0, 0, 1, 0, 32'h10);
        chk("lit_wcall_pc8", {24'h0, pc8}, 32'h10);
        cyc(0, 0, 0, 1, 0);
        chk("lit_wret_pc8", {24'h0, pc8}, RAS_ON ? 32'h0 : 32'h11);
        chk("lit_wret_pc0", pc0, RAS_ON ? 32'h0 : 32'h11);

        // Reset in the middle of a call sequence discards the stack.
        cyc(0, 0, 1, 0, 32'h55);
        rst = 1'b1;
        cyc(0, 0, 1, 0, 32'h66);
        rst = 1'b0;
        chk("lit_mrst_pc", pc0, 32'h0);
        chk("lit_mrst_empty", {31'h0, emp0}, 32'h1);
        cyc(0, 0, 0, 1, 0);
        chk("lit_mrst_ret_pc", pc0, 32'h1);
        chk("lit_mrst_uf", {31'h0, uf0}, {31'h0, RAS_ON});
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the CPU fetch stage. It generalises the basic PC in three ways: address width, increment and reset vector are parameters; a stall input holds fetch; an optional return-address stack (RAS) supports call/return. It sits between the branch/decode logic (which supplies target and control strobes) and the instruction memory address port.

## Interface
Parameters:
- `ADDR_W`, 32: PC width in bits.
- `INC`, 1: sequential increment. 1 means word addressing, one instruction per address.
- `RESET_VEC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: return-address stack entries. Must be a power of 2 and ≥2.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hold the PC and all state this cycle.
- `branch` input 1: load `branchAdrx`.
- `call` input 1: load `branchAdrx` and push the return address.
- `ret` input 1: load the RAS top and pop it.
- `branchAdrx` input ADDR_W: branch/call target.
- `pc` output ADDR_W: current fetch address, registered.
- `ras_empty` output 1: the stack holds 0 entries.
- `ras_full` output 1: the stack holds RAS_DEPTH entries.
- `ras_underflow` output 1: registered one-cycle pulse, set when a `ret` is issued with an empty stack.

## Operation
- Priority per cycle: `rst` > `stall` > `ret` > `call` > `branch` > increment.
- Increment: `pc <= pc + INC`, modulo 2^ADDR_W. Wrap from all-ones past 0 is silent.
- `branch`: `pc <= branchAdrx`. The stack is unchanged.
- `call`: `pc <= branchAdrx` and push `pc + INC` (modulo 2^ADDR_W).
- `ret` with a non-empty stack: `pc <= top` and pop.
- `ret` with an empty stack: `pc <= pc + INC`. The stack is unchanged and `ras_underflow` is 1 next cycle.
- `call` while full: circular overwrite of the oldest entry. The count saturates at RAS_DEPTH, so `ras_full` stays 1. The most recent RAS_DEPTH return addresses are preserved.
- `ret` and `call` both asserted: `ret` wins and `call` is ignored. The same rule applies when `branch` is also asserted.
- `stall`: pc, stack, pointer and count all hold, and `ras_underflow` goes 0. Control strobes are ignored.
- Stack state: write pointer wp (log2 RAS_DEPTH bits) and count cnt (0..RAS_DEPTH).
  - Push: mem[wp] <= data, wp++, cnt = min(cnt+1, RAS_DEPTH).
  - Pop: wp--, cnt--.
  - top = mem[wp-1].

## Timing
- Reset values: `pc`=RESET_VEC, wp=0, cnt=0, `ras_empty`=1, `ras_full`=0, `ras_underflow`=0. Stack contents are don't-care.
- Reset asserted mid-call/ret sequence discards all stack contents on that edge.
- Latency: a strobe sampled at edge N gives the new `pc` visible after edge N.
- `ras_empty`/`ras_full` are decoded from registered cnt and reflect the state after the last edge.
- No back-to-back hazards: a `ret` immediately following a `call` returns the just-pushed address.

## Configuration
- `PC_RAS_EN` defined: the RAS is built and behaves as above.
- `PC_RAS_EN` undefined:
  - No stack storage.
  - `call` behaves exactly as `branch`.
  - `ret` behaves as increment.
  - `ras_empty`=1, `ras_full`=0, `ras_underflow`=0 constantly.
  - Ports remain present.

## Structure
- Shared package `pc_pkg`:
  - enum `pc_op_t` {PC_HOLD, PC_INC, PC_BRANCH, PC_CALL, PC_RET}, produced by the priority decode.
  - default constants for ADDR_W, INC, RESET_VEC.
- One sub-module `ras_stack`: circular LIFO with push/pop/top/cnt, parametrised by ADDR_W and RAS_DEPTH. It is instantiated only under `PC_RAS_EN`.

## Test plan
1. Reset and increment: assert `rst` for 2 cycles → `pc`=0. Release → `pc`=1,2,3 on successive edges. With INC=4 and RESET_VEC=0x100 → 0x100, 0x104, 0x108.
2. Call/return: from `pc`=5, `call` to 0x40 → `pc`=0x40. Two idle cycles → 0x42. `ret` → `pc`=6, `ras_empty`=1.
3. Overflow: RAS_DEPTH=4, 5 nested calls pushing return addresses A1..A5 → `ras_full`=1. 4 rets → A5, A4, A3, A2. A 5th ret → `pc`=pc+1 and `ras_underflow` pulses for 1 cycle.
4. Stall and priority: `stall` with `call` asserted → `pc` and cnt unchanged. `ret`+`call`+`branch` together with top=0x20 → `pc`=0x20 and cnt decrements.
5. Wrap: ADDR_W=8, `pc`=0xFF, increment → 0x00. `call` at 0xFF pushes 0x00.
6. Macro off: `call` to 0x30 → `pc`=0x30. `ret` → `pc`=0x31, `ras_empty` stays 1.
